mem_arbiter: RTL and testbench

- Sequential arbiter sharing the single-ported RAM between the instruction fetch port and the data (LW/SW) port of the pipelined MIPS datapath.
- Accepts fetch requests, and the load/store requests the control unit raises via dmemreq/dmemwreq.
- Grants one transaction at a time, holds it until the RAM signals completion, then returns the data to the requester.
- Data has priority; a fairness bit prevents fetch starvation; a watchdog flags a hung RAM.

---
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported RAM between instruction fetch and data access.
// Data wins by default; a fairness bit lets a waiting fetch go next; a watchdog traps a hung RAM.
module mem_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] iload,
    output logic          iwait,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dstore,
    output logic [DW-1:0] dload,
    output logic          dwait,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [DW-1:0] ramstore,
    input  logic [DW-1:0] ramload,
    input  logic          ram_ready,
    output logic          error
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        IREAD,
        DREAD,
        DWRITE,
        ERROR
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          fair;
    logic          busy;
    logic          done;

    assign busy    = (state == IREAD) || (state == DREAD) || (state == DWRITE);
    assign done    = busy && ram_ready;
    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (fair && iREN)  state_n = IREAD;
                else if (dWEN)     state_n = DWRITE;
                else if (dREN)     state_n = DREAD;
                else if (iREN)     state_n = IREAD;
            end
            IREAD, DREAD, DWRITE: begin
                // Completion beats timeout when both land in the same cycle
                if (ram_ready)            state_n = IDLE;
                else if (cnt_inc == TMAX) state_n = ERROR;
            end
            ERROR:   state_n = ERROR;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            cnt    <= '0;
            fair   <= 1'b0;
            error  <= 1'b0;
            iload  <= '0;
            dload  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                cnt <= '0;
                if (state_n == IREAD) begin
                    addr_q <= iaddr;
                    fair   <= 1'b0;
                end else if (state_n == DREAD || state_n == DWRITE) begin
                    addr_q <= daddr;
                    if (state_n == DWRITE) data_q <= dstore;
                end
            end else if (busy && !ram_ready) begin
                cnt <= cnt_inc;
            end
            if (done && state != IREAD && iREN) fair <= 1'b1;
            if (done && state == IREAD) iload <= ramload;
            if (done && state == DREAD) dload <= ramload;
            if (state_n == ERROR) error <= 1'b1;
        end
    end

    assign ramREN   = (state == IREAD) || (state == DREAD);
    assign ramWEN   = (state == DWRITE);
    assign ramaddr  = busy ? addr_q : '0;
    assign ramstore = (state == DWRITE) ? data_q : '0;

    assign iwait = !(done && state == IREAD && iREN);
    assign dwait = !(done && ((state == DREAD && dREN) || (state == DWRITE && dWEN)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, conflict/fairness, store, drop,
// reset mid-write, timeout boundary and watchdog trap.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic        ram_ready = 1'b0;
    logic        error;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.TIMEOUT(15), .AW(32), .DW(32)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready),
        .error(error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " ramREN"}, 32'(ramREN), 0);
        chk({tag, " ramWEN"}, 32'(ramWEN), 0);
        chk({tag, " ramaddr"}, ramaddr, 0);
        chk({tag, " ramstore"}, ramstore, 0);
        chk({tag, " iwait"}, 32'(iwait), 1);
        chk({tag, " dwait"}, 32'(dwait), 1);
        chk({tag, " iload"}, iload, 0);
        chk({tag, " dload"}, dload, 0);
        chk({tag, " error"}, 32'(error), 0);
    endtask

    initial begin
        #12;
        chk_reset_outs("reset");
        RST = 1'b0;

        // single fetch, ready after 2 busy cycles
        iREN = 1; iaddr = 32'h40;
        cyc();
        chk("f1 ramREN", 32'(ramREN), 1);
        chk("f1 ramaddr", ramaddr, 32'h40);
        chk("f1 iwait", 32'(iwait), 1);
        cyc();
        chk("f2 ramREN", 32'(ramREN), 1);
        cyc();
        chk("f3 ramREN", 32'(ramREN), 1);
        chk("f3 ramaddr", ramaddr, 32'h40);
        ram_ready = 1; ramload = 32'h8C01_0004;
        #1;
        chk("f3 iwait", 32'(iwait), 0);
        chk("f3 ramWEN", 32'(ramWEN), 0);
        cyc();
        ram_ready = 0; iREN = 0;
        #1;
        chk("f iload", iload, 32'h8C01_0004);
        chk("f idle ramREN", 32'(ramREN), 0);
        chk("f idle iwait", 32'(iwait), 1);

        // conflict: data first, then fairness lets fetch in
        iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100;
        cyc();
        chk("c1 ramaddr", ramaddr, 32'h100);
        chk("c1 ramREN", 32'(ramREN), 1);
        ram_ready = 1; ramload = 32'hAAAA_0001;
        #1;
        chk("c1 dwait", 32'(dwait), 0);
        chk("c1 iwait", 32'(iwait), 1);
        cyc();
        ram_ready = 0;
        #1;
        chk("c1 dload", dload, 32'hAAAA_0001);
        chk("c idle ramREN", 32'(ramREN), 0);
        cyc();
        chk("c2 fair ramaddr", ramaddr, 32'h44);
        ram_ready = 1; ramload = 32'h1111_1111;
        #1;
        chk("c2 iwait", 32'(iwait), 0);
        chk("c2 dwait", 32'(dwait), 1);
        cyc();
        ram_ready = 0; iREN = 0;
        #1;
        chk("c2 iload", iload, 32'h1111_1111);
        cyc();
        chk("c3 ramaddr", ramaddr, 32'h100);
        chk("c3 ramREN", 32'(ramREN), 1);
        ram_ready = 1; ramload = 32'h2222_2222;
        cyc();
        ram_ready = 0; dREN = 0;
        #1;
        chk("c3 dload", dload, 32'h2222_2222);

        // store: write wins over read, data latched at grant
        dWEN = 1; dREN = 1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
        cyc();
        chk("s1 ramWEN", 32'(ramWEN), 1);
        chk("s1 ramREN", 32'(ramREN), 0);
        chk("s1 ramaddr", ramaddr, 32'h200);
        dstore = 0; daddr = 32'h300;
        #1;
        chk("s1 ramstore", ramstore, 32'hDEAD_BEEF);
        chk("s1 ramaddr held", ramaddr, 32'h200);
        cyc();
        chk("s2 ramREN", 32'(ramREN), 0);
        chk("s2 ramstore", ramstore, 32'hDEAD_BEEF);
        ram_ready = 1;
        #1;
        chk("s2 dwait", 32'(dwait), 0);
        cyc();
        ram_ready = 0; dWEN = 0; dREN = 0;
        #1;
        chk("s idle ramWEN", 32'(ramWEN), 0);
        chk("s dload kept", dload, 32'h2222_2222);

        // dropped fetch
        iREN = 1; iaddr = 32'h80;
        cyc();
        chk("d1 ramaddr", ramaddr, 32'h80);
        iREN = 0;
        cyc();
        ram_ready = 1; ramload = 32'h1234_5678;
        #1;
        chk("d iwait", 32'(iwait), 1);
        cyc();
        ram_ready = 0;
        #1;
        chk("d iload", iload, 32'h1234_5678);
        chk("d idle ramREN", 32'(ramREN), 0);

        // timeout boundary: ready on the 15th busy cycle completes
        dREN = 1; daddr = 32'h500;
        cyc();
        for (int i = 0; i < 14; i++) cyc();
        chk("b15 ramREN", 32'(ramREN), 1);
        ram_ready = 1; ramload = 32'h0BAD_F00D;
        #1;
        chk("b15 dwait", 32'(dwait), 0);
        cyc();
        ram_ready = 0; dREN = 0;
        #1;
        chk("b error", 32'(error), 0);
        chk("b dload", dload, 32'h0BAD_F00D);

        // reset in the middle of a write
        dWEN = 1; daddr = 32'h204; dstore = 32'h55;
        cyc();
        chk("r ramWEN", 32'(ramWEN), 1);
        #2;
        RST = 1;
        #1;
        chk("r async ramWEN", 32'(ramWEN), 0);
        chk("r async ramaddr", ramaddr, 0);
        dWEN = 0;
        #3;
        RST = 0;
        cyc();
        chk_reset_outs("r after");

        // watchdog: 15 busy cycles without ready
        dREN = 1; daddr = 32'h400;
        cyc();
        for (int i = 0; i < 14; i++) cyc();
        chk("w14 error", 32'(error), 0);
        chk("w14 ramREN", 32'(ramREN), 1);
        cyc();
        chk("w error", 32'(error), 1);
        chk("w ramREN", 32'(ramREN), 0);
        chk("w dwait", 32'(dwait), 1);
        ram_ready = 1;
        cyc();
        #1;
        chk("w ignore ready dwait", 32'(dwait), 1);
        cyc();
        chk("w stuck error", 32'(error), 1);
        chk("w stuck ramREN", 32'(ramREN), 0);
        ram_ready = 0;
        RST = 1;
        #3;
        chk("w rst error", 32'(error), 0);
        RST = 0;
        cyc();
        chk("w regrant ramREN", 32'(ramREN), 1);
        chk("w regrant ramaddr", ramaddr, 32'h400);
        dREN = 0;
        ram_ready = 1;
        cyc();
        ram_ready = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
